uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and UART-side signals for uart_tx_arbiter.
// Each link is valid/ready: a byte moves on any cycle where both are high, and valid never waits on ready.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           w_data;
    logic                 w_valid;
    logic                 w_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic                 timeout_err;
    logic [3:0]           err_id;
    logic [1:0]           dbg_state;

    modport slave (
        input  req_data, req_valid, req_last, w_ready,
        output req_ready, w_data, w_valid, grant, busy, timeout_err, err_id, dbg_state
    );

    modport master (
        output req_data, req_valid, req_last, w_ready,
        input  req_ready, w_data, w_valid, grant, busy, timeout_err, err_id, dbg_state
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that merges byte packets from NUM_REQ requesters onto one UART write port,
// optionally prefixing each packet with an A<id> header and aborting packets whose owner starves the bus.
module uart_tx_arbiter #(
    parameter int          NUM_REQ   = 4,
    parameter bit          HEADER_EN = 1'b1,
    parameter logic [15:0] TIMEOUT   = 16'd1000
) (
    input logic             clk,
    input logic             rst_n,
    uart_tx_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HEADER  = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;

    localparam logic [3:0]  RR_INIT  = 4'(NUM_REQ - 1);
    // Abort fires on the starved cycle whose increment would bring the counter to TIMEOUT-1.
    localparam logic [15:0] TO_LIMIT = (TIMEOUT == 16'd0) ? 16'd0 : TIMEOUT - 16'd1;

    logic [1:0]         state_q, state_d;
    logic [3:0]         gnt_idx_q, gnt_idx_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [3:0]         rr_ptr_q, rr_ptr_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               timeout_err_q, timeout_err_d;
    logic [3:0]         err_id_q, err_id_d;

    logic               arb_found;
    logic [3:0]         arb_idx;
    logic [NUM_REQ-1:0] arb_onehot;
    logic [4:0]         arb_dist;
    logic [4:0]         best_dist;

    logic               pay_valid;
    logic               pay_last;
    logic [7:0]         pay_data;
    logic [16:0]        cnt_inc;

    logic [7:0]         w_data_c;
    logic               w_valid_c;
    logic [NUM_REQ-1:0] req_ready_c;

    // Winner is the valid requester at the smallest upward distance from rr_ptr+1.
    always_comb begin
        arb_found  = 1'b0;
        arb_idx    = 4'd0;
        arb_onehot = '0;
        best_dist  = 5'd31;
        arb_dist   = 5'd0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (5'(j) > {1'b0, rr_ptr_q}) begin
                arb_dist = 5'(j) - {1'b0, rr_ptr_q} - 5'd1;
            end else begin
                arb_dist = 5'(j) + 5'(NUM_REQ) - {1'b0, rr_ptr_q} - 5'd1;
            end
            if (bus.req_valid[j] && (arb_dist < best_dist)) begin
                best_dist     = arb_dist;
                arb_found     = 1'b1;
                arb_idx       = 4'(j);
                arb_onehot    = '0;
                arb_onehot[j] = 1'b1;
            end
        end
    end

    always_comb begin
        pay_valid = 1'b0;
        pay_last  = 1'b0;
        pay_data  = 8'd0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_q[j]) begin
                pay_valid = bus.req_valid[j];
                pay_last  = bus.req_last[j];
                pay_data  = bus.req_data[8*j +: 8];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        gnt_idx_d     = gnt_idx_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
        err_id_d      = err_id_q;
        w_valid_c     = 1'b0;
        w_data_c      = 8'd0;
        req_ready_c   = '0;
        cnt_inc       = {1'b0, cnt_q} + 17'd1;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 16'd0;
                if (arb_found) begin
                    gnt_idx_d = arb_idx;
                    grant_d   = arb_onehot;
                    state_d   = HEADER_EN ? ST_HEADER : ST_PAYLOAD;
                end
            end

            ST_HEADER: begin
                w_valid_c = 1'b1;
                w_data_c  = {4'hA, gnt_idx_q};
                if (bus.w_ready) begin
                    state_d = ST_PAYLOAD;
                    cnt_d   = 16'd0;
                end
            end

            ST_PAYLOAD: begin
                w_valid_c   = pay_valid;
                w_data_c    = pay_data;
                req_ready_c = grant_q & {NUM_REQ{bus.w_ready}};
                if (pay_valid && bus.w_ready) begin
                    cnt_d = 16'd0;
                    if (pay_last) begin
                        state_d  = ST_IDLE;
                        grant_d  = '0;
                        rr_ptr_d = gnt_idx_q;
                    end
                end else if (!pay_valid) begin
                    // Only an absent requester counts; UART back-pressure never aborts a packet.
                    if (cnt_inc >= {1'b0, TO_LIMIT}) begin
                        timeout_err_d = 1'b1;
                        err_id_d      = gnt_idx_q;
                        rr_ptr_d      = gnt_idx_q;
                        grant_d       = '0;
                        cnt_d         = 16'd0;
                        state_d       = ST_IDLE;
                    end else begin
                        cnt_d = cnt_inc[15:0];
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                cnt_d   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            gnt_idx_q     <= 4'd0;
            grant_q       <= '0;
            rr_ptr_q      <= RR_INIT;
            cnt_q         <= 16'd0;
            timeout_err_q <= 1'b0;
            err_id_q      <= 4'd0;
        end else begin
            state_q       <= state_d;
            gnt_idx_q     <= gnt_idx_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
            err_id_q      <= err_id_d;
        end
    end

    assign bus.w_valid     = w_valid_c;
    assign bus.w_data      = w_data_c;
    assign bus.req_ready   = req_ready_c;
    assign bus.grant       = grant_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.timeout_err = timeout_err_q;
    assign bus.err_id      = err_id_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a header-enabled instance (TIMEOUT=8) and a header-less one.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int          NREQ = 4;
    localparam int          W    = 8 + NREQ;
    localparam logic [15:0] TO   = 16'd8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NREQ)) hif_h ();
    uart_tx_arbiter_if #(.NUM_REQ(NREQ)) hif_n ();

    uart_tx_arbiter #(.NUM_REQ(NREQ), .HEADER_EN(1'b1), .TIMEOUT(TO)) dut_h (
        .clk(clk), .rst_n(rst_n), .bus(hif_h)
    );
    uart_tx_arbiter #(.NUM_REQ(NREQ), .HEADER_EN(1'b0), .TIMEOUT(TO)) dut_n (
        .clk(clk), .rst_n(rst_n), .bus(hif_n)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_n_q[$];
    logic [3:0]   to_q[$];

    int cyc        = 0;
    int last_xfer  = 0;
    int xfer_total = 0;
    bit rdy_chk    = 1'b0;
    int rdy_base   = 0;

    logic [7:0] rq_byte [NREQ][16];
    bit         rq_last [NREQ][16];
    int         rq_cnt  [NREQ];
    int         rq_idx  [NREQ];
    int         wr_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h, expected nothing", name, act);
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        return NREQ'(1 << i);
    endfunction

    function automatic logic [7:0] pb(input int r, input int p, input int k);
        return 8'(r * 64 + p * 8 + k + 1);
    endfunction

    always @(negedge clk) begin : mon_h
        int           n;
        logic [NREQ-1:0] er;
        logic [W-1:0] e;
        logic [3:0]   eid;
        cyc++;
        if (rdy_chk) begin
            n  = xfer_total - rdy_base;
            er = ((n >= 1) && (n < 4) && hif_h.w_ready) ? 4'b0100 : 4'b0000;
            chk("req_ready_r2", 32'(hif_h.req_ready), 32'(er));
        end
        if (rst_n && hif_h.w_valid && hif_h.w_ready) begin
            xfer_total++;
            last_xfer = cyc;
            if (exp_q.size() == 0) begin
                note_fail("uart_extra_byte", 32'({hif_h.grant, hif_h.w_data}));
            end else begin
                e = exp_q.pop_front();
                chk("uart_grant_byte", 32'({hif_h.grant, hif_h.w_data}), 32'(e));
            end
        end
        if (hif_h.timeout_err) begin
            if (to_q.size() == 0) begin
                note_fail("timeout_unexpected", 32'(hif_h.err_id));
            end else begin
                eid = to_q.pop_front();
                chk("timeout_gap", 32'(cyc - last_xfer), 32'd8);
                chk("timeout_err_id", 32'(hif_h.err_id), 32'(eid));
            end
        end
    end

    always @(negedge clk) begin : mon_n
        logic [W-1:0] e;
        if (rst_n && hif_n.w_valid && hif_n.w_ready) begin
            if (exp_n_q.size() == 0) begin
                note_fail("n_uart_extra_byte", 32'({hif_n.grant, hif_n.w_data}));
            end else begin
                e = exp_n_q.pop_front();
                chk("n_uart_grant_byte", 32'({hif_n.grant, hif_n.w_data}), 32'(e));
            end
        end
        if (hif_n.timeout_err) note_fail("n_timeout_unexpected", 32'(hif_n.err_id));
    end

    task automatic apply_h();
        for (int i = 0; i < NREQ; i++) begin
            if (rq_idx[i] < rq_cnt[i]) begin
                hif_h.req_valid[i]       = 1'b1;
                hif_h.req_data[8*i +: 8] = rq_byte[i][rq_idx[i]];
                hif_h.req_last[i]        = rq_last[i][rq_idx[i]];
            end else begin
                hif_h.req_valid[i]       = 1'b0;
                hif_h.req_data[8*i +: 8] = 8'd0;
                hif_h.req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic clear_rq();
        for (int i = 0; i < NREQ; i++) begin
            rq_cnt[i] = 0;
            rq_idx[i] = 0;
        end
    endtask

    task automatic push_byte(input int r, input logic [7:0] b, input bit last);
        rq_byte[r][rq_cnt[r]] = b;
        rq_last[r][rq_cnt[r]] = last;
        rq_cnt[r]++;
    endtask

    task automatic exp_h(input logic [NREQ-1:0] g, input logic [7:0] d);
        exp_q.push_back({g, d});
    endtask

    task automatic step();
        logic [NREQ-1:0] fire;
        @(negedge clk);
        fire = hif_h.req_valid & hif_h.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) if (fire[i]) rq_idx[i]++;
        apply_h();
        case (wr_mode)
            0:       hif_h.w_ready = 1'b1;
            1:       hif_h.w_ready = ~hif_h.w_ready;
            default: hif_h.w_ready = 1'b0;
        endcase
    endtask

    task automatic run_idle(input int limit, input string name);
        int k;
        bit done;
        k    = 0;
        done = 1'b0;
        while (!done && (k < limit)) begin
            step();
            k++;
            done = !hif_h.busy && (exp_q.size() == 0) && (to_q.size() == 0);
            for (int i = 0; i < NREQ; i++) if (rq_idx[i] < rq_cnt[i]) done = 1'b0;
        end
        if (!done) note_fail(name, 32'(k));
    endtask

    task automatic check_reset(input string p);
        chk({p, "_h_grant"},     32'(hif_h.grant),       32'd0);
        chk({p, "_h_req_ready"}, 32'(hif_h.req_ready),   32'd0);
        chk({p, "_h_w_valid"},   32'(hif_h.w_valid),     32'd0);
        chk({p, "_h_w_data"},    32'(hif_h.w_data),      32'd0);
        chk({p, "_h_busy"},      32'(hif_h.busy),        32'd0);
        chk({p, "_h_timeout"},   32'(hif_h.timeout_err), 32'd0);
        chk({p, "_h_err_id"},    32'(hif_h.err_id),      32'd0);
        chk({p, "_h_state"},     32'(hif_h.dbg_state),   32'd0);
        chk({p, "_n_grant"},     32'(hif_n.grant),       32'd0);
        chk({p, "_n_w_valid"},   32'(hif_n.w_valid),     32'd0);
        chk({p, "_n_busy"},      32'(hif_n.busy),        32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        hif_h.req_valid = '0;
        hif_h.req_data  = '0;
        hif_h.req_last  = '0;
        hif_h.w_ready   = 1'b1;
        hif_n.req_valid = '0;
        hif_n.req_data  = '0;
        hif_n.req_last  = '0;
        hif_n.w_ready   = 1'b1;
        clear_rq();

        // Reset values
        repeat (3) @(posedge clk);
        #2;
        check_reset("rst0");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All four requesters valid, 2-byte packets: grants 0,1,2,3,0
        clear_rq();
        wr_mode = 0;
        for (int r = 0; r < NREQ; r++) begin
            push_byte(r, pb(r, 0, 0), 1'b0);
            push_byte(r, pb(r, 0, 1), 1'b1);
        end
        push_byte(0, pb(0, 1, 0), 1'b0);
        push_byte(0, pb(0, 1, 1), 1'b1);
        for (int s = 0; s < 5; s++) begin
            exp_h(oh(s % 4), {4'hA, 4'(s % 4)});
            exp_h(oh(s % 4), pb(s % 4, s / 4, 0));
            exp_h(oh(s % 4), pb(s % 4, s / 4, 1));
        end
        apply_h();
        run_idle(200, "t1_round_robin_done");

        // Requester 2, three bytes, w_ready toggling every cycle
        clear_rq();
        push_byte(2, 8'h11, 1'b0);
        push_byte(2, 8'h22, 1'b0);
        push_byte(2, 8'h33, 1'b1);
        exp_h(oh(2), 8'hA2);
        exp_h(oh(2), 8'h11);
        exp_h(oh(2), 8'h22);
        exp_h(oh(2), 8'h33);
        rdy_base = xfer_total;
        rdy_chk  = 1'b1;
        wr_mode  = 1;
        apply_h();
        run_idle(100, "t2_toggle_done");
        rdy_chk = 1'b0;
        wr_mode = 0;
        hif_h.w_ready = 1'b1;

        // Requester 3 starves after one byte; requester 0 waits and is served next
        clear_rq();
        push_byte(3, 8'h3C, 1'b0);
        push_byte(0, 8'h0D, 1'b1);
        exp_h(oh(3), 8'hA3);
        exp_h(oh(3), 8'h3C);
        to_q.push_back(4'd3);
        exp_h(oh(0), 8'hA0);
        exp_h(oh(0), 8'h0D);
        apply_h();
        run_idle(200, "t3_timeout_done");
        chk("t3_err_id_hold", 32'(hif_h.err_id), 32'd3);

        // Long back-pressure in HEADER never times out
        clear_rq();
        push_byte(1, 8'h77, 1'b1);
        exp_h(oh(1), 8'hA1);
        exp_h(oh(1), 8'h77);
        wr_mode = 2;
        hif_h.w_ready = 1'b0;
        apply_h();
        step();
        for (int c = 0; c < 5000; c++) begin
            chk("t4_w_data",     32'(hif_h.w_data),      32'h0A1);
            chk("t4_w_valid",    32'(hif_h.w_valid),     32'd1);
            chk("t4_no_timeout", 32'(hif_h.timeout_err), 32'd0);
            step();
        end
        wr_mode = 0;
        hif_h.w_ready = 1'b1;
        run_idle(50, "t4_header_stall_done");

        // Asynchronous reset during payload byte 2 of 4
        clear_rq();
        for (int b = 0; b < 4; b++) push_byte(1, 8'hB0 + 8'(b), b == 3);
        exp_h(oh(1), 8'hA1);
        exp_h(oh(1), 8'hB0);
        base = xfer_total;
        k = 0;
        apply_h();
        while (((xfer_total - base) < 2) && (k < 50)) begin
            step();
            k++;
        end
        chk("t5_reached_byte2", 32'(xfer_total - base), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("t5_async");
        clear_rq();
        apply_h();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_byte(0, 8'hC0, 1'b1);
        push_byte(2, 8'hC2, 1'b1);
        exp_h(oh(0), 8'hA0);
        exp_h(oh(0), 8'hC0);
        exp_h(oh(2), 8'hA2);
        exp_h(oh(2), 8'hC2);
        apply_h();
        run_idle(100, "t5_after_reset_done");

        // Header-less instance: one-byte packet 5C from requester 1
        @(posedge clk);
        #1;
        hif_n.w_ready           = 1'b1;
        hif_n.req_data[15:8]    = 8'h5C;
        hif_n.req_last[1]       = 1'b1;
        hif_n.req_valid[1]      = 1'b1;
        exp_n_q.push_back({oh(1), 8'h5C});
        #1;
        chk("t6_idle_w_valid", 32'(hif_n.w_valid), 32'd0);
        chk("t6_idle_busy",    32'(hif_n.busy),    32'd0);
        @(posedge clk);
        #1;
        chk("t6_w_valid", 32'(hif_n.w_valid), 32'd1);
        chk("t6_w_data",  32'(hif_n.w_data),  32'h05C);
        chk("t6_busy",    32'(hif_n.busy),    32'd1);
        chk("t6_grant",   32'(hif_n.grant),   32'(oh(1)));
        @(posedge clk);
        #1;
        hif_n.req_valid = '0;
        hif_n.req_last  = '0;
        hif_n.req_data  = '0;
        #1;
        chk("t6_busy_end",  32'(hif_n.busy),    32'd0);
        chk("t6_grant_end", 32'(hif_n.grant),   32'd0);
        chk("t6_w_valid_end", 32'(hif_n.w_valid), 32'd0);

        repeat (5) @(posedge clk);
        #1;
        chk("exp_q_drained",   32'(exp_q.size()),   32'd0);
        chk("exp_n_q_drained", 32'(exp_n_q.size()), 32'd0);
        chk("to_q_drained",    32'(to_q.size()),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
